// File: rtl/count_monitor_if.sv
// count_monitor_if
// Bundles the observed count stream and the monitor's decoded results.
//   count_valid : qualifies count on the current clock edge
//   count       : observed counter value (WIDTH bits)
//   dir         : recovered direction, 1 = up, 0 = down
//   locked      : direction is locked
//   wrap        : one-cycle pulse on a boundary unit step
//   dir_change  : one-cycle pulse on a reversal while locked
//   step_err    : one-cycle pulse on a non-unit, non-zero step
//   err_count   : saturating count of step_err pulses
// The master side drives the count stream and observes the results;
// the slave side is the monitor itself.
interface count_monitor_if #(
  parameter int WIDTH = 4
);
  logic             count_valid;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             locked;
  logic             wrap;
  logic             dir_change;
  logic             step_err;
  logic [7:0]       err_count;

  modport master (
    output count_valid, count,
    input  dir, locked, wrap, dir_change, step_err, err_count
  );

  modport slave (
    input  count_valid, count,
    output dir, locked, wrap, dir_change, step_err, err_count
  );
endinterface

// File: rtl/count_monitor.sv
// count_monitor
// Receive-side checker for an up/down counter output. Classifies each
// accepted sample against the previous one, recovers the counting
// direction once enough consecutive same-direction unit steps are seen,
// and flags wrap-arounds, direction reversals and illegal jumps.
// Ports:
//   clock : single clock, rising-edge active
//   reset : synchronous, active-high, overrides every other input
//   mon   : count_monitor_if slave modport (count stream in, results out)
// Parameters:
//   WIDTH    : width of the observed count
//   LOCK_LEN : consecutive same-direction unit steps needed to lock (1..15)
module count_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 3
) (
  input  logic           clock,
  input  logic           reset,
  count_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX      = '1;
  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_LEN);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             has_prev_q, has_prev_d;
  logic [3:0]       run_q, run_d;
  logic             cand_q, cand_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             wrap_q, wrap_d;
  logic             dir_change_q, dir_change_d;
  logic             step_err_q, step_err_d;
  logic [7:0]       err_count_q, err_count_d;

  logic [WIDTH-1:0] delta;
  logic             is_up;
  logic             is_down;
  logic             is_unit;
  logic             is_jump;
  logic             is_wrap;

  // Step classification. The subtraction is modulo 2^WIDTH, so a step
  // across the boundary still looks like a unit step.
  always_comb begin
    delta   = mon.count - prev_q;
    is_up   = (delta == ONE);
    is_down = (delta == MAX);
    is_unit = is_up || is_down;
    is_jump = !is_unit && (delta != '0);
    is_wrap = (is_up && (mon.count == '0)) || (is_down && (mon.count == MAX));
  end

  // Next-state and registered-output logic. Every pulse defaults low, so
  // an edge without count_valid clears them while all other state holds.
  // The lock test uses >= so a run that is already at LOCK_LEN when the
  // FSM re-enters ACQUIRE (possible with LOCK_LEN = 1) still locks.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    has_prev_d   = has_prev_q;
    run_d        = run_q;
    cand_d       = cand_q;
    dir_d        = dir_q;
    locked_d     = locked_q;
    wrap_d       = 1'b0;
    dir_change_d = 1'b0;
    step_err_d   = 1'b0;
    err_count_d  = err_count_q;

    if (mon.count_valid) begin
      prev_d     = mon.count;
      has_prev_d = 1'b1;
      wrap_d     = has_prev_q && is_wrap;

      unique case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          run_d   = 4'd0;
        end

        ACQUIRE: begin
          if (is_unit) begin
            if ((run_q == 4'd0) || (is_up == cand_q)) begin
              run_d = 4'(run_q + 4'd1);
            end else begin
              run_d = 4'd1;
            end
            cand_d = is_up;
            if (run_d >= LOCK_RUN) begin
              state_d  = LOCKED;
              dir_d    = is_up;
              locked_d = 1'b1;
            end
          end else if (is_jump) begin
            run_d      = 4'd0;
            step_err_d = 1'b1;
          end
        end

        LOCKED: begin
          if (is_unit && (is_up != dir_q)) begin
            dir_change_d = 1'b1;
            state_d      = ACQUIRE;
            run_d        = 4'd1;
            cand_d       = is_up;
            locked_d     = 1'b0;
          end else if (is_jump) begin
            step_err_d = 1'b1;
            state_d    = ACQUIRE;
            run_d      = 4'd0;
            locked_d   = 1'b0;
          end
        end

        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase

      if (step_err_d && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  // State register with synchronous reset that clears every flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      has_prev_q   <= 1'b0;
      run_q        <= 4'd0;
      cand_q       <= 1'b0;
      dir_q        <= 1'b0;
      locked_q     <= 1'b0;
      wrap_q       <= 1'b0;
      dir_change_q <= 1'b0;
      step_err_q   <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      has_prev_q   <= has_prev_d;
      run_q        <= run_d;
      cand_q       <= cand_d;
      dir_q        <= dir_d;
      locked_q     <= locked_d;
      wrap_q       <= wrap_d;
      dir_change_q <= dir_change_d;
      step_err_q   <= step_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign mon.dir        = dir_q;
  assign mon.locked     = locked_q;
  assign mon.wrap       = wrap_q;
  assign mon.dir_change = dir_change_q;
  assign mon.step_err   = step_err_q;
  assign mon.err_count  = err_count_q;

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor
// Self-checking bench for count_monitor (WIDTH = 4, LOCK_LEN = 3).
// A table of {reset, valid, count, expected outputs} records is built at
// the start and replayed one clock per record; a hand-written loop then
// drives the alternating 0/8 stream that saturates err_count.
module tb_count_monitor;

  logic clock;
  logic reset;

  count_monitor_if #(.WIDTH(4)) mon_if ();

  count_monitor #(
    .WIDTH   (4),
    .LOCK_LEN(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mon  (mon_if.slave)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [3:0] cnt;
    logic       dir;
    logic       locked;
    logic       wrap;
    logic       dc;
    logic       serr;
    logic [7:0] ecnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic addVec(input logic rst, input logic valid, input logic [3:0] cnt,
                        input logic dir, input logic locked, input logic wrap,
                        input logic dc, input logic serr, input logic [7:0] ecnt);
    vec_t v;
    v.rst = rst; v.valid = valid; v.cnt = cnt;
    v.dir = dir; v.locked = locked; v.wrap = wrap;
    v.dc = dc; v.serr = serr; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  // Drive inputs away from the active edge, then let one rising edge pass
  // and settle so outputs can be sampled safely.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [3:0] cnt);
    @(negedge clock);
    reset              = rst;
    mon_if.count_valid = valid;
    mon_if.count       = cnt;
    @(posedge clock);
    #1;
  endtask

  task automatic compareField(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic dir, input logic locked,
                             input logic wrap, input logic dc, input logic serr,
                             input logic [7:0] ecnt);
    compareField({tag, ".dir"},        8'(mon_if.dir),        8'(dir));
    compareField({tag, ".locked"},     8'(mon_if.locked),     8'(locked));
    compareField({tag, ".wrap"},       8'(mon_if.wrap),       8'(wrap));
    compareField({tag, ".dir_change"}, 8'(mon_if.dir_change), 8'(dc));
    compareField({tag, ".step_err"},   8'(mon_if.step_err),   8'(serr));
    compareField({tag, ".err_count"},  mon_if.err_count,      ecnt);
  endtask

  initial begin
    int exp_ecnt;

    reset              = 1'b1;
    mon_if.count_valid = 1'b0;
    mon_if.count       = 4'd0;

    // Up lock across the boundary: lock and wrap both land on sample 0.
    addVec(1, 0,  0, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 13, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 14, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 15, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  0, 1, 1, 1, 0, 0, 0);
    addVec(0, 1,  1, 1, 1, 0, 0, 0, 0);

    // Down lock from 15 (first sample never flagged), run down to 0, wrap to 15.
    addVec(1, 0,  0, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 15, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 14, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 13, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 12, 0, 1, 0, 0, 0, 0);
    for (int c = 11; c >= 0; c--) addVec(0, 1, 4'(c), 0, 1, 0, 0, 0, 0);
    addVec(0, 1, 15, 0, 1, 1, 0, 0, 0);

    // Reversal: locked up at 5, then counting down relocks after 2.
    addVec(1, 0,  0, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  2, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  3, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  4, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  5, 1, 1, 0, 0, 0, 0);
    addVec(0, 1,  4, 1, 0, 0, 1, 0, 0);
    addVec(0, 1,  3, 1, 0, 0, 0, 0, 0);
    addVec(0, 1,  2, 0, 1, 0, 0, 0, 0);
    addVec(0, 1,  1, 0, 1, 0, 0, 0, 0);

    // Jump: locked up at 7, then 10 is an illegal step; relock after 13.
    addVec(1, 0,  0, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  4, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  5, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  6, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  7, 1, 1, 0, 0, 0, 0);
    addVec(0, 1, 10, 1, 0, 0, 0, 1, 1);
    addVec(0, 1, 11, 1, 0, 0, 0, 0, 1);
    addVec(0, 1, 12, 1, 0, 0, 0, 0, 1);
    addVec(0, 1, 13, 1, 1, 0, 0, 0, 1);

    // Reset with count_valid high while locked clears everything, and the
    // following sample (far from the old prev) is not flagged.
    addVec(1, 1,  3, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  9, 0, 0, 0, 0, 0, 0);
    addVec(0, 1, 10, 0, 0, 0, 0, 0, 0);

    // Holds and gaps are transparent; lock lands on sample 5.
    addVec(1, 0,  0, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  2, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  2, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  3, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 5; g++) addVec(0, 0, 9, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  4, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  4, 0, 0, 0, 0, 0, 0);
    addVec(0, 1,  5, 1, 1, 0, 0, 0, 0);

    // Keep counting up to a wrap, then a gap must clear the pulse only.
    for (int c = 6; c <= 15; c++) addVec(0, 1, 4'(c), 1, 1, 0, 0, 0, 0);
    addVec(0, 1,  0, 1, 1, 1, 0, 0, 0);
    addVec(0, 0,  7, 1, 1, 0, 0, 0, 0);
    addVec(0, 0,  7, 1, 1, 0, 0, 0, 0);
    addVec(0, 1,  1, 1, 1, 0, 0, 0, 0);

    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].cnt);
      checkOutput($sformatf("vec%0d", i), vecs[i].dir, vecs[i].locked, vecs[i].wrap,
                  vecs[i].dc, vecs[i].serr, vecs[i].ecnt);
    end

    // Saturation: after reset, alternating 0/8 makes every sample but the
    // first a jump, so err_count climbs by one per sample and sticks at 255.
    $display("[TB] saturation sequence");
    applyStimulus(1'b1, 1'b0, 4'd0);
    checkOutput("sat_reset", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b1, (i % 2 == 1) ? 4'd8 : 4'd0);
      exp_ecnt = (i > 255) ? 255 : i;
      checkOutput($sformatf("sat%0d", i), 0, 0, 0, 0, (i > 0) ? 1'b1 : 1'b0, 8'(exp_ecnt));
    end
    applyStimulus(1'b0, 1'b0, 4'd8);
    checkOutput("sat_gap", 0, 0, 0, 0, 0, 8'd255);
    applyStimulus(1'b1, 1'b1, 4'd0);
    checkOutput("sat_clear", 0, 0, 0, 0, 0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
# count_monitor

Receive-side checker for the 4-bit up/down counter output. Samples a count stream and recovers the counting direction. Locks once the direction is stable, and flags wrap-arounds, direction reversals and illegal steps. Sits downstream of the counter, alongside any logic that consumes `count`, as a self-checking monitor and direction decoder.

## Interface

Parameters:
- `WIDTH`, default 4: width of the observed count.
- `LOCK_LEN`, default 3: consecutive same-direction unit steps needed to lock. Legal range 1..15.

Ports:
- `clock`  in  1  single clock; all activity on its rising edge.
- `reset`  in  1  synchronous, active-high; wins over every other input.
- `count_valid`  in  1  `count` is sampled on this edge.
- `count`  in  WIDTH  observed counter value.
- `dir`  out  1  recovered direction: 1 = up, 0 = down. Meaningful while `locked`=1.
- `locked`  out  1  direction is locked.
- `wrap`  out  1  one-cycle pulse: unit step across the boundary (up max→0, down 0→max).
- `dir_change`  out  1  one-cycle pulse: opposite-direction unit step while locked.
- `step_err`  out  1  one-cycle pulse: non-unit, non-zero step.
- `err_count`  out  8  saturating count of `step_err` pulses.

## Operation

- A sample is accepted when `count_valid`=1. Accepted samples are stored as `prev`; the `has_prev` flag is set on the first one.
- Step classification uses `delta = count - prev` modulo 2^WIDTH, computed at WIDTH bits:
  - `delta`=1: UP.
  - `delta`=all ones: DOWN.
  - `delta`=0: HOLD. Legal; no state change; no pulse.
  - Anything else: JUMP.
- Internal `run` counter (4 bits) and candidate direction `cand`.
- States:
  - IDLE: no `prev` yet. The first accepted sample goes to ACQUIRE with `run`=0. No pulses.
  - ACQUIRE:
    - UP/DOWN matching `cand`, or any unit step when `run`=0: set `cand` to the step direction, `run`+1.
    - Opposite unit step: `cand` = new direction, `run`=1.
    - JUMP: `run`=0.
    - When `run` reaches `LOCK_LEN`: go to LOCKED, set `dir`=`cand`, assert `locked`.
  - LOCKED:
    - Step in `dir` or HOLD: stay.
    - Opposite unit step: pulse `dir_change`, go to ACQUIRE with `run`=1, `cand` = new direction, drop `locked`.
    - JUMP: pulse `step_err`, go to ACQUIRE with `run`=0, drop `locked`.
- `step_err` pulses on JUMP in ACQUIRE and LOCKED. It never pulses in IDLE.
- `wrap` pulses on any boundary unit step once `has_prev`=1, in any state. It may coincide with `dir_change`.
- `err_count` increments on each `step_err` and saturates at 255.
- `dir` holds its last locked value after lock is lost.

## Timing

- All outputs are registered. The response to the sample accepted at edge N is visible after edge N (one-cycle latency).
- Pulses (`wrap`, `dir_change`, `step_err`) last exactly one cycle. They are 0 in any cycle following an edge with `count_valid`=0.
- `count_valid`=0: state, `prev`, `run`, `dir`, `locked` and `err_count` all hold. Gaps of any length are transparent.
- `reset`=1 at an edge clears everything regardless of `count_valid`:
  - state goes to IDLE; `has_prev`=0, `run`=0.
  - Outputs clear: `dir`=0, `locked`=0, `wrap`=0, `dir_change`=0, `step_err`=0, `err_count`=0.
- The first sample after reset is never an error, whatever its value (e.g. 15 from a down-counter reset).
- With `LOCK_LEN`=N and a clean stream, `locked` rises after the (N+1)th accepted sample.

## Test plan

- Up lock and wrap:
  - Stimulus: reset, then valid samples 13,14,15,0,1.
  - Response: `locked`=1 and `dir`=1 after sample 0, which is also where `wrap` pulses once. No `step_err`.
- Down lock:
  - Stimulus: samples 15,14,13,12, then 0,15.
  - Response: `locked`=1 and `dir`=0 after 12. `wrap` pulses after 15. `err_count` stays 0.
- Reversal:
  - Stimulus: locked up at 5, then 4,3,2,1.
  - Response: `dir_change` pulse and `locked`=0 after 4. Relocks with `dir`=0 after 2.
- Jump:
  - Stimulus: locked up at 7, then 10,11,12,13.
  - Response: `step_err` pulse and `locked`=0 after 10, `err_count`=1. Relocks after 13.
- Holds and gaps:
  - Stimulus: samples 2,2,3, `count_valid`=0 for 5 cycles, then 4,4,5.
  - Response: locks after 5. Holds and gaps produce no pulses; no outputs change during the gap.
- Reset mid-lock and saturation:
  - Stimulus 1: assert `reset` with `count_valid`=1 while locked.
  - Response 1: all outputs 0, and the next sample is not flagged.
  - Stimulus 2: 300 alternating 0/8 samples.
  - Response 2: `err_count` holds at 255.
